// File: rtl/tdc_multi_ch_stamper.sv
// Multi-channel TDC timestamper: shared coarse counter, per-channel hit holding,
// round-robin arbitration into a FWFT FIFO. Optional macro: TDC_ROLLOVER_MARK_EN.
module tdc_multi_ch_stamper #(
    parameter  int NUM_CH       = 4,
    parameter  int FINE_WIDTH   = 8,
    parameter  int COARSE_WIDTH = 16,
    parameter  int FIFO_DEPTH   = 16,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DW           = 1 + CH_W + COARSE_WIDTH + FINE_WIDTH,
    localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic [NUM_CH-1:0]            i_fine_valid,
    input  logic [NUM_CH*FINE_WIDTH-1:0] i_fine_code,
    input  logic                         i_ready,
    output logic                         o_valid,
    output logic [DW-1:0]                o_dout,
    output logic [LW-1:0]                o_level,
    output logic                         o_full,
    output logic [15:0]                  o_drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [COARSE_WIDTH-1:0] r_coarse;
    logic [COARSE_WIDTH-1:0] r_hold_coarse [NUM_CH];
    logic [FINE_WIDTH-1:0]   r_hold_fine   [NUM_CH];
    logic [NUM_CH-1:0]       r_pend;
    logic [CH_W-1:0]         r_last;
    logic [DW-1:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [LW-1:0]           r_level;
    logic [15:0]             r_drop_cnt;

    logic                    w_space;
    logic                    w_gnt_any;
    logic [CH_W-1:0]         w_gnt_idx;
    logic [NUM_CH-1:0]       w_gnt_vec;
    logic [NUM_CH-1:0]       w_cap;
    logic [NUM_CH-1:0]       w_drop_vec;
    logic [5:0]              w_drop_num;
    logic [16:0]             w_drop_sum;
    logic                    w_push;
    logic                    w_pop;
    logic [DW-1:0]           w_word;
    logic                    w_mark_sel;
    logic                    w_mark_drop;
    logic [DW-1:0]           w_mark_word;

    function automatic int rr_next(input int base, input int off);
        int s;
        s = base + off;
        return (s >= NUM_CH) ? (s - NUM_CH) : s;
    endfunction

    assign w_space = (r_level != LW'(FIFO_DEPTH));

`ifdef TDC_ROLLOVER_MARK_EN
    logic                    r_mark_pend;
    logic [COARSE_WIDTH-1:0] r_epoch;
    logic                    w_wrap;

    assign w_wrap      = i_en && (r_coarse == {COARSE_WIDTH{1'b1}});
    assign w_mark_sel  = r_mark_pend && w_space;
    assign w_mark_drop = w_wrap && r_mark_pend && !w_mark_sel;
    assign w_mark_word = {1'b1, {CH_W{1'b0}}, r_epoch, {FINE_WIDTH{1'b0}}};

    // Rollover epoch count and pending marker request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mark_pend <= 1'b0;
            r_epoch     <= '0;
        end else if (w_wrap) begin
            r_mark_pend <= 1'b1;
            r_epoch     <= r_epoch + {{(COARSE_WIDTH-1){1'b0}}, 1'b1};
        end else if (w_mark_sel) begin
            r_mark_pend <= 1'b0;
        end else begin
            r_mark_pend <= r_mark_pend;
        end
    end
`else
    assign w_mark_sel  = 1'b0;
    assign w_mark_drop = 1'b0;
    assign w_mark_word = '0;
`endif

    // Round-robin grant starting after the last granted channel; markers take precedence
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt_vec = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_gnt_any && w_space && !w_mark_sel && r_pend[rr_next(int'(r_last), i)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = CH_W'(rr_next(int'(r_last), i));
                w_gnt_vec[rr_next(int'(r_last), i)] = 1'b1;
            end else begin
                w_gnt_any = w_gnt_any;
            end
        end
    end

    // A hit is only lost when its slot is occupied and not being drained this cycle
    always_comb begin
        w_cap      = i_fine_valid & (~r_pend | w_gnt_vec);
        w_drop_vec = i_fine_valid & r_pend & ~w_gnt_vec;
        w_drop_num = {5'd0, w_mark_drop};
        for (int i = 0; i < NUM_CH; i++) begin
            w_drop_num = w_drop_num + {5'd0, w_drop_vec[i]};
        end
        w_drop_sum = {1'b0, r_drop_cnt} + {11'd0, w_drop_num};
    end

    assign w_push = w_gnt_any || w_mark_sel;
    assign w_pop  = o_valid && i_ready;
    assign w_word = w_mark_sel ? w_mark_word
                               : {1'b0, w_gnt_idx, r_hold_coarse[w_gnt_idx], r_hold_fine[w_gnt_idx]};

    // Coarse counter, holding registers, arbiter pointer and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coarse   <= '0;
            r_pend     <= '0;
            r_last     <= CH_W'(NUM_CH - 1);
            r_drop_cnt <= 16'd0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_hold_coarse[k] <= '0;
                r_hold_fine[k]   <= '0;
            end
        end else begin
            r_coarse   <= i_en ? (r_coarse + {{(COARSE_WIDTH-1){1'b0}}, 1'b1}) : r_coarse;
            r_last     <= w_gnt_any ? w_gnt_idx : r_last;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            r_pend     <= w_cap | (r_pend & ~w_gnt_vec);
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_cap[k]) begin
                    r_hold_coarse[k] <= r_coarse;
                    r_hold_fine[k]   <= i_fine_code[k*FINE_WIDTH +: FINE_WIDTH];
                end else begin
                    r_hold_coarse[k] <= r_hold_coarse[k];
                    r_hold_fine[k]   <= r_hold_fine[k];
                end
            end
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr <= w_push ? (r_wptr + AW'(1)) : r_wptr;
            r_rptr <= w_pop  ? (r_rptr + AW'(1)) : r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_valid    = (r_level != '0);
    assign o_full     = (r_level == LW'(FIFO_DEPTH));
    assign o_level    = r_level;
    assign o_dout     = o_valid ? r_mem[r_rptr] : '0;
    assign o_drop_cnt = r_drop_cnt;
endmodule
